dds_freq_meter: RTL and testbench

DDS_FREQ_METER -- requirements
Module: dds_freq_meter

---
 rtl/dds_meter_pkg.sv | 16 +
 rtl/dds_cross_det.sv | 39 +++
 rtl/dds_freq_meter.sv | 125 ++++++++++++
 tb/tb_dds_freq_meter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dds_meter_pkg.sv
// dds_meter_pkg: FSM state type, default parameters and small helpers shared by the DDS frequency meter.
package dds_meter_pkg;

    localparam int DATA_W      = 10;
    localparam int HYST        = 16;
    localparam int CNT_W       = 32;
    localparam int TIMEOUT_CYC = 1 << 24;

    typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

    // A request for zero periods is measured as a single period.
    function automatic logic [7:0] norm_periods(input logic [7:0] n);
        return (n == 8'd0) ? 8'd1 : n;
    endfunction

endpackage

// File: rtl/dds_cross_det.sv
// dds_cross_det: hysteresis crossing detector; arms on a valid sample below MID-HYST,
// then pulses evt once on the first valid sample at or above MID+HYST.
module dds_cross_det #(
    parameter int DATA_W = dds_meter_pkg::DATA_W,
    parameter int HYST   = dds_meter_pkg::HYST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_vld,
    input  logic              clear,
    output logic              evt
);

    localparam int W1  = DATA_W + 1;
    localparam int MID = 1 << (DATA_W - 1);
    localparam logic [DATA_W:0] LO = W1'(MID - HYST);
    localparam logic [DATA_W:0] HI = W1'(MID + HYST);

    logic armed;
    logic lo;
    logic hi;

    assign lo  = sample_vld && ({1'b0, sample} < LO);
    assign hi  = sample_vld && ({1'b0, sample} >= HI);
    assign evt = armed && hi && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            armed <= 1'b0;
        else if (clear)
            armed <= 1'b0;
        else if (lo)
            armed <= 1'b1;
        else if (hi)
            armed <= 1'b0;
    end

endmodule

// File: rtl/dds_freq_meter.sv
// dds_freq_meter: counts clk cycles spanned by n_periods waveform periods of a sampled signal.
// Optional measurement watchdog is enabled by defining DDS_FREQ_METER_TIMEOUT_EN.
module dds_freq_meter #(
    parameter int DATA_W      = dds_meter_pkg::DATA_W,
    parameter int HYST        = dds_meter_pkg::HYST,
    parameter int CNT_W       = dds_meter_pkg::CNT_W,
    parameter int TIMEOUT_CYC = dds_meter_pkg::TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_vld,
    input  logic              start,
    input  logic [7:0]        n_periods,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic              timeout
);

    import dds_meter_pkg::*;

`ifdef DDS_FREQ_METER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int               WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]  WD_LIM  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] cyc;
    logic [7:0]       per;
    logic [7:0]       n_lat;
    logic [WD_W-1:0]  wd;
    logic             evt;
    logic             accept;
    logic             last;
    logic             wd_hit;

    assign accept = (state == IDLE) && start;
    assign last   = evt && (per + 8'd1 == n_lat);
    // wd equals cycles elapsed since the accepted start; hitting WD_LIM puts done exactly TIMEOUT_CYC after start.
    assign wd_hit = TO_EN && (wd >= WD_LIM);

    dds_cross_det #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_det (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample     (sample),
        .sample_vld (sample_vld),
        .clear      (accept),
        .evt        (evt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cyc_cnt <= '0;
            timeout <= 1'b0;
            cyc     <= '0;
            per     <= '0;
            n_lat   <= '0;
            wd      <= '0;
        end else begin
            done <= 1'b0;
            if (wd != '1)
                wd <= wd + 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ARM;
                        busy    <= 1'b1;
                        timeout <= 1'b0;
                        n_lat   <= norm_periods(n_periods);
                        cyc     <= '0;
                        per     <= '0;
                        wd      <= WD_W'(1);
                    end
                end
                ARM: begin
                    if (wd_hit) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cyc_cnt <= '0;
                        timeout <= 1'b1;
                    end else if (evt) begin
                        // The first event cycle counts as 0, so cyc reads 1 on the cycle after it.
                        state <= MEAS;
                        cyc   <= CNT_W'(1);
                        per   <= '0;
                    end
                end
                MEAS: begin
                    if (cyc != CNT_MAX)
                        cyc <= cyc + 1'b1;
                    if (evt)
                        per <= per + 8'd1;
                    if (last) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cyc_cnt <= cyc;
                    end else if (wd_hit) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cyc_cnt <= '0;
                        timeout <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_freq_meter.sv
// tb_dds_freq_meter: sine-ROM DDS stimulus; a period-timing reference model feeds a scoreboard
// that a done-driven monitor drains. Timeout cases are included when DDS_FREQ_METER_TIMEOUT_EN is defined.
module tb_dds_freq_meter;

    localparam int DW  = 10;
    localparam int HY  = 16;
    localparam int CW  = 32;
    localparam int TO  = 1000;
    localparam int MID = 1 << (DW - 1);

`ifdef DDS_FREQ_METER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [CW-1:0] cyc;
        logic          to;
        int            at;
    } exp_t;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic [DW-1:0] sample     = '0;
    logic          sample_vld = 1'b0;
    logic          start      = 1'b0;
    logic [7:0]    n_periods  = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] cyc_cnt;
    logic          timeout;

    int   cyc_now = 0;
    int   n_vec   = 0;
    int   n_err   = 0;
    exp_t sb[$];
    int   rom[1024];
    int   noise[256];

    dds_freq_meter #(
        .DATA_W      (DW),
        .HYST        (HY),
        .CNT_W       (CW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample     (sample),
        .sample_vld (sample_vld),
        .start      (start),
        .n_periods  (n_periods),
        .busy       (busy),
        .done       (done),
        .cyc_cnt    (cyc_cnt),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_now <= cyc_now + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_now);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_done: got done=1, expected no result at cycle %0d", cyc_now);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("cyc_cnt", 64'(cyc_cnt), 64'(e.cyc));
                chk("timeout", 64'(timeout), 64'(e.to));
                chk("done_cycle", 64'(cyc_now), 64'(e.at));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    function automatic logic [DW-1:0] dds(input logic [31:0] ph, input bit noisy);
        int v;
        v = rom[ph[31:22]] + (noisy ? noise[ph[31:24]] : 0);
        v = (v < 0) ? 0 : (v > 1023) ? 1023 : v;
        return DW'(v);
    endfunction

    task automatic drive(input bit v, input logic [DW-1:0] s, input bit st, input logic [7:0] n);
        @(posedge clk);
        #1;
        sample_vld = v;
        sample     = s;
        start      = st;
        n_periods  = n;
    endtask

    // vmode: 0 = valid every cycle, 1 = valid every 2nd cycle, 2 = random valid plus stray starts.
    // fixed >= 0 gives the expected cyc_cnt directly; otherwise the model's event distance is used.
    task automatic measure(input logic [31:0] k, input int vmode, input logic [7:0] n,
                           input bit noisy, input longint fixed, input int rst_at);
        logic [31:0]   ph;
        logic [DW-1:0] s;
        logic [7:0]    nx;
        bit            armed;
        bit            fin;
        bit            v;
        bit            st;
        int            s0;
        int            first;
        int            cnt;
        int            nn;
        int            c;
        ph    = '0;
        armed = 1'b0;
        fin   = 1'b0;
        first = -1;
        cnt   = 0;
        nn    = (n == 8'd0) ? 1 : int'(n);
        for (int i = 0; i < 3; i++) drive(1'b1, '0, 1'b0, 8'd0);
        drive(1'b1, '0, 1'b1, n);
        s0 = cyc_now;
        for (int i = 1; !fin && i < 30000; i++) begin
            v  = (vmode == 0) || (vmode == 1 && i % 2 == 0) || (vmode == 2 && $urandom_range(99) < 70);
            s  = v ? dds(ph, noisy) : DW'($urandom);
            if (v) ph = ph + k;
            st = (vmode == 2) && ($urandom_range(199) == 0);
            nx = 8'($urandom);
            drive(v, s, st, nx);
            c = cyc_now;
            if (v && s < MID - HY) begin
                armed = 1'b1;
            end else if (v && s >= MID + HY) begin
                if (armed) begin
                    if (first < 0) begin
                        first = c;
                    end else begin
                        cnt++;
                        if (cnt == nn) begin
                            sb.push_back('{(fixed >= 0) ? CW'(fixed) : CW'(c - first), 1'b0, c + 1});
                            fin = 1'b1;
                        end
                    end
                end
                armed = 1'b0;
            end
            if (TO_EN && !fin && c == s0 + TO - 1) begin
                sb.push_back('{'0, 1'b1, c + 1});
                fin = 1'b1;
            end
            if (i == 1) begin
                @(negedge clk);
                chk("busy_after_start", 64'(busy), 64'd1);
                chk("timeout_cleared", 64'(timeout), 64'd0);
            end
            if (i == rst_at) begin
                #1 rst_n = 1'b0;
                @(negedge clk);
                chk("busy_in_reset", 64'(busy), 64'd0);
                chk("cyc_cnt_in_reset", 64'(cyc_cnt), 64'd0);
                chk("done_in_reset", 64'(done), 64'd0);
                @(posedge clk);
                #1 rst_n = 1'b1;
                fin = 1'b1;
            end
        end
        if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL measure_budget: got no final event, expected one within 30000 cycles");
        end
        for (int i = 0; i < 8 && sb.size() > 0; i++) drive(1'b0, '0, 1'b0, 8'd0);
        if (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL missing_done: got no done, expected done at cycle %0d", sb[0].at);
            sb.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++)
            rom[i] = int'(511.5 + 511.0 * $sin(6.283185307179586 * i / 1024.0));
        for (int i = 0; i < 256; i++)
            noise[i] = int'($urandom_range(2 * (HY - 1))) - (HY - 1);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_cyc_cnt", 64'(cyc_cnt), 64'd0);
        chk("reset_timeout", 64'(timeout), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        measure(32'h0100_0000, 0, 8'd4, 1'b0, 1024, 0);
        measure(32'h0200_0000, 1, 8'd4, 1'b0, 1024, 0);
        measure(32'h0100_0000, 0, 8'd0, 1'b0, 256, 0);
        measure(32'h0100_0000, 0, 8'd2, 1'b1, 512, 0);
        measure(32'h0100_0000, 0, 8'd4, 1'b0, -1, 600);
        measure(32'h0100_0000, 0, 8'd4, 1'b0, 1024, 0);
`ifdef DDS_FREQ_METER_TIMEOUT_EN
        measure(32'h0000_0000, 0, 8'd4, 1'b0, -1, 0);
        measure(32'h0000_0000, 0, 8'd1, 1'b0, -1, 0);
`endif
        for (int t = 0; t < 8; t++)
            measure($urandom_range(32'h0400_0000, 32'h0100_0000), int'($urandom_range(2)),
                    8'($urandom_range(5)), 1'($urandom_range(1)), -1, 0);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
